// File: rtl/riscv_test_status_pkg.sv
// Shared command codes and channel state encoding for the test status controller.
// Types and constants only; no logic.
package riscv_test_status_pkg;

    localparam logic [3:0] CMD_PASS  = 4'h5;
    localparam logic [3:0] CMD_FAIL  = 4'hC;
    localparam logic [3:0] CMD_DEBUG = 4'hA;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2,
        ST_TOUT = 2'd3
    } ch_state_e;

endpackage

// File: rtl/riscv_test_status_ctrl_if.sv
// Core data-bus write port into the test status controller.
// Write-only strobe bus: no handshake and no backpressure, every ce&we cycle is consumed.
interface riscv_test_status_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              ce;
    logic              we;
    logic [31:0]       addr;
    logic [DATA_W-1:0] data;

    modport master (output ce, we, addr, data);
    modport slave  (input  ce, we, addr, data);
endinterface

// File: rtl/riscv_status_sync.sv
// Reset-clearable flop chain delaying a status vector by STAGES cycles.
// Latency STAGES cycles (0 = wire); no backpressure.
module riscv_status_sync #(
    parameter int W      = 1,
    parameter int STAGES = 3
) (
    input  logic         clk,
    input  logic         resetb,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    generate
        if (STAGES == 0) begin : g_direct
            assign dout = din;
        end else begin : g_pipe
            logic [W-1:0] pipe_q [STAGES];
            logic [W-1:0] pipe_d [STAGES];

            always_comb begin
                pipe_d[0] = din;
                for (int s = 1; s < STAGES; s++) begin
                    pipe_d[s] = pipe_q[s-1];
                end
            end

            always_ff @(posedge clk or negedge resetb) begin
                if (!resetb) begin
                    for (int s = 0; s < STAGES; s++) begin
                        pipe_q[s] <= '0;
                    end
                end else begin
                    pipe_q <= pipe_d;
                end
            end

            assign dout = pipe_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/riscv_test_status_ctrl.sv
// Per-hart end-of-test / debug mailbox with a watchdog and a global cycle counter.
// Status outputs lag the channel state by SYNC_STAGES cycles; bus writes are never stalled.
module riscv_test_status_ctrl
    import riscv_test_status_pkg::*;
#(
    parameter int          N_CH           = 2,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_01FF,
    parameter int          DATA_W         = 8,
    parameter int          SYNC_STAGES    = 3,
    parameter int          CNT_W          = 32,
    parameter int          TIMEOUT_CYCLES = 0
) (
    input  logic                         clk,
    input  logic                         resetb,
    riscv_test_status_ctrl_if.slave      bus,
    output logic [N_CH-1:0]              ready_out,
    output logic [N_CH-1:0]              fail_out,
    output logic                         timeout_out,
    output logic                         all_done_out,
    output logic [N_CH-1:0]              debug_out,
    output logic [N_CH*(DATA_W-4)-1:0]   exit_code_out,
    output logic [CNT_W-1:0]             cycle_count_out
);

    localparam int CODE_W = DATA_W - 4;
    localparam int VEC_W  = 2 * N_CH + 2;

    ch_state_e         state_q [N_CH];
    ch_state_e         state_d [N_CH];
    logic [CODE_W-1:0] code_q  [N_CH];
    logic [CODE_W-1:0] code_d  [N_CH];
    logic [N_CH-1:0]   debug_q, debug_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout_q, timeout_d;

    logic [N_CH-1:0]   hit, term, failbit;
    logic              any_run, any_run_next, tout_fire;
    logic [3:0]        cmd;
    logic [CODE_W-1:0] wcode;
    logic [VEC_W-1:0]  stat_vec, stat_dly;
    logic              unused_addr_hi;

    assign cmd            = bus.data[3:0];
    assign wcode          = bus.data[DATA_W-1:4];
    assign unused_addr_hi = ^bus.addr[31:30];

    always_comb begin
        hit     = '0;
        term    = '0;
        failbit = '0;
        any_run = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            hit[c]     = bus.ce & bus.we & (bus.addr[29:0] == BASE_ADDR[29:0] + 30'(c));
            term[c]    = (state_q[c] != ST_RUN);
            failbit[c] = (state_q[c] == ST_FAIL) || (state_q[c] == ST_TOUT);
            if (state_q[c] == ST_RUN) any_run = 1'b1;
        end
    end

    assign tout_fire = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES)) && any_run;

    always_comb begin
        debug_d      = debug_q;
        timeout_d    = timeout_q | tout_fire;
        any_run_next = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            state_d[c] = state_q[c];
            code_d[c]  = code_q[c];
            if (hit[c] && cmd == CMD_DEBUG) debug_d[c] = ~debug_q[c];
            // An explicit verdict written on the timeout cycle beats the watchdog.
            if (state_q[c] == ST_RUN) begin
                if (hit[c] && cmd == CMD_PASS) begin
                    state_d[c] = ST_PASS;
                    code_d[c]  = wcode;
                end else if (hit[c] && cmd == CMD_FAIL) begin
                    state_d[c] = ST_FAIL;
                    code_d[c]  = wcode;
                end else if (tout_fire) begin
                    state_d[c] = ST_TOUT;
                end
            end
            if (state_d[c] == ST_RUN) any_run_next = 1'b1;
        end
        // Gate on next state so the edge that ends the last channel does not count.
        cnt_d = cnt_q;
        if (any_run_next && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            for (int c = 0; c < N_CH; c++) begin
                state_q[c] <= ST_RUN;
                code_q[c]  <= '0;
            end
            debug_q   <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            debug_q   <= debug_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign stat_vec = {&term, timeout_q, failbit, term};

    riscv_status_sync #(
        .W      (VEC_W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .resetb (resetb),
        .din    (stat_vec),
        .dout   (stat_dly)
    );

    assign ready_out       = stat_dly[N_CH-1:0];
    assign fail_out        = stat_dly[2*N_CH-1:N_CH];
    assign timeout_out     = stat_dly[2*N_CH];
    assign all_done_out    = stat_dly[2*N_CH+1];
    assign debug_out       = debug_q;
    assign cycle_count_out = cnt_q;

    always_comb begin
        exit_code_out = '0;
        for (int c = 0; c < N_CH; c++) begin
            exit_code_out[c*CODE_W +: CODE_W] = code_q[c];
        end
    end

endmodule

// File: tb/tb_riscv_test_status_ctrl.sv
// Directed bench: one instance without watchdog, one with TIMEOUT_CYCLES=20.
module tb_riscv_test_status_ctrl;
    import riscv_test_status_pkg::*;

    logic clk;
    logic resetb;
    int   total;
    int   bad;

    logic [1:0]  ready0, fail0, debug0, ready1, fail1, debug1;
    logic        tout0, done0, tout1, done1;
    logic [7:0]  exit0, exit1;
    logic [31:0] cnt0, cnt1;

    riscv_test_status_ctrl_if #(.DATA_W(8)) if0 ();
    riscv_test_status_ctrl_if #(.DATA_W(8)) if1 ();

    riscv_test_status_ctrl #(
        .N_CH(2), .BASE_ADDR(32'h0000_01FF), .DATA_W(8),
        .SYNC_STAGES(3), .CNT_W(32), .TIMEOUT_CYCLES(0)
    ) dut0 (
        .clk(clk), .resetb(resetb), .bus(if0),
        .ready_out(ready0), .fail_out(fail0), .timeout_out(tout0),
        .all_done_out(done0), .debug_out(debug0), .exit_code_out(exit0),
        .cycle_count_out(cnt0)
    );

    riscv_test_status_ctrl #(
        .N_CH(2), .BASE_ADDR(32'h0000_01FF), .DATA_W(8),
        .SYNC_STAGES(3), .CNT_W(32), .TIMEOUT_CYCLES(20)
    ) dut1 (
        .clk(clk), .resetb(resetb), .bus(if1),
        .ready_out(ready1), .fail_out(fail1), .timeout_out(tout1),
        .all_done_out(done1), .debug_out(debug1), .exit_code_out(exit1),
        .cycle_count_out(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one bus cycle that is sampled on the next edge; returns #1 after it.
    task automatic bus_op(input int sel, input logic [31:0] a, input logic [7:0] d, input logic w);
        if (sel == 0) begin
            if0.ce = 1'b1; if0.we = w; if0.addr = a; if0.data = d;
        end else begin
            if1.ce = 1'b1; if1.we = w; if1.addr = a; if1.data = d;
        end
        @(posedge clk);
        #1;
        if0.ce = 1'b0; if0.we = 1'b0;
        if1.ce = 1'b0; if1.we = 1'b0;
    endtask

    task automatic do_reset();
        resetb = 1'b0;
        tick(2);
        resetb = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        resetb = 1'b0;
        if0.ce = 1'b0; if0.we = 1'b0; if0.addr = '0; if0.data = '0;
        if1.ce = 1'b0; if1.we = 1'b0; if1.addr = '0; if1.data = '0;
        tick(3);

        // Reset state
        chk("rst_ready", ready0, 0);
        chk("rst_fail", fail0, 0);
        chk("rst_tout", tout0, 0);
        chk("rst_done", done0, 0);
        chk("rst_debug", debug0, 0);
        chk("rst_exit", exit0, 0);
        chk("rst_cnt", cnt0, 0);

        // PASS ch0 at edge 4, FAIL ch1 at edge 8
        resetb = 1'b1;
        tick(3);
        chk("cnt_run", cnt0, 3);
        bus_op(0, 32'h0000_01FF, 8'h35, 1'b1);
        chk("pass_lat0", ready0, 2'b00);
        tick(2);
        chk("pass_lat2", ready0, 2'b00);
        tick(1);
        chk("pass_ready", ready0, 2'b01);
        chk("pass_fail", fail0, 2'b00);
        chk("pass_code", exit0[3:0], 4'h3);
        bus_op(0, 32'h0000_0200, 8'h7C, 1'b1);
        tick(2);
        chk("done_lat2", done0, 0);
        tick(1);
        chk("fail_ready", ready0, 2'b11);
        chk("fail_fail", fail0, 2'b10);
        chk("fail_code", exit0[7:4], 4'h7);
        chk("all_done", done0, 1);
        chk("cnt_frozen", cnt0, 7);

        // Debug toggles, status untouched
        bus_op(0, 32'h0000_01FF, 8'h0A, 1'b1);
        chk("dbg_1", debug0, 2'b01);
        bus_op(0, 32'h0000_01FF, 8'h0A, 1'b1);
        chk("dbg_2", debug0, 2'b00);
        bus_op(0, 32'h0000_01FF, 8'h0A, 1'b1);
        chk("dbg_3", debug0, 2'b01);
        chk("dbg_ready", ready0, 2'b11);

        // Second PASS in terminal state keeps exit code
        bus_op(0, 32'h0000_01FF, 8'h95, 1'b1);
        tick(3);
        chk("repass_code", exit0, 8'h73);
        chk("repass_fail", fail0, 2'b10);
        chk("cnt_still", cnt0, 7);

        // Address decode and reads
        do_reset();
        bus_op(0, 32'h0000_01FE, 8'h35, 1'b1);
        bus_op(0, 32'h0000_01FF, 8'h35, 1'b0);
        tick(4);
        chk("miss_ready", ready0, 2'b00);
        chk("miss_code", exit0, 8'h00);
        bus_op(0, 32'hC000_01FF, 8'h45, 1'b1);
        tick(3);
        chk("hi_ready", ready0, 2'b01);
        chk("hi_code", exit0, 8'h04);

        // Reset between write and ready_out
        do_reset();
        bus_op(0, 32'h0000_01FF, 8'h0A, 1'b1);
        bus_op(0, 32'h0000_0200, 8'h15, 1'b1);
        tick(1);
        resetb = 1'b0;
        #1;
        chk("mid_ready", ready0, 2'b00);
        chk("mid_exit", exit0, 8'h00);
        chk("mid_debug", debug0, 2'b00);
        chk("mid_cnt", cnt0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("mid_hold", ready0, 2'b00);
        end
        resetb = 1'b1;
        tick(2);
        chk("mid_restart", cnt0, 2);
        tick(2);
        chk("mid_nopulse", ready0, 2'b00);

        // Watchdog: PASS ch0 at edge 5, ch1 times out
        do_reset();
        tick(4);
        bus_op(1, 32'h0000_01FF, 8'h25, 1'b1);
        tick(15);
        chk("wd_cnt20", cnt1, 20);
        tick(3);
        chk("wd_lat", tout1, 0);
        tick(1);
        chk("wd_tout", tout1, 1);
        chk("wd_fail", fail1, 2'b10);
        chk("wd_ready", ready1, 2'b11);
        chk("wd_done", done1, 1);
        chk("wd_code", exit1, 8'h02);
        tick(10);
        chk("wd_cnt_hold", cnt1, 20);

        // PASS ch1 on the exact timeout cycle wins
        do_reset();
        tick(4);
        bus_op(1, 32'h0000_01FF, 8'h25, 1'b1);
        tick(15);
        bus_op(1, 32'h0000_0200, 8'h95, 1'b1);
        tick(3);
        chk("race_ready", ready1, 2'b11);
        chk("race_fail", fail1, 2'b00);
        chk("race_code", exit1, 8'h92);
        chk("race_cnt", cnt1, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_test_status_ctrl.md
Name: riscv_test_status_ctrl

Overview:
- Memory-mapped end-of-test and debug controller for multi-hart RISC-V test programs.
- Each hart (channel) owns one magic word address on the core data bus. Software writes a command nibble plus an exit code there to signal pass, fail or debug toggle.
- Per-channel status leaves through a parametrised synchroniser delay toward the chip-level test harness.
- A global cycle counter enforces a watchdog timeout on channels that never report.

Parameters:
N_CH, 2, number of channels (harts); 1..8
BASE_ADDR, 32'h0000_01FF, address of channel 0; channel c decodes at BASE_ADDR+c
DATA_W, 8, write-data width; [3:0]=command, [DATA_W-1:4]=exit code; minimum 5
SYNC_STAGES, 3, flop stages on status outputs; 0 = direct
CNT_W, 32, cycle counter width
TIMEOUT_CYCLES, 0, watchdog limit in cycles; 0 disables the watchdog

Ports:
clk  in  1  clock
resetb  in  1  asynchronous active-low reset
ce  in  1  bus access strobe
we  in  1  write enable, qualified by ce
addr  in  32  byte address; only addr[29:0] is compared
data  in  DATA_W  write data
ready_out  out  N_CH  channel terminated (pass, fail or timeout), delayed
fail_out  out  N_CH  channel terminated by fail or timeout, delayed
timeout_out  out  1  watchdog fired, delayed
all_done_out  out  1  every channel terminated, delayed
debug_out  out  N_CH  per-channel debug toggle, undelayed
exit_code_out  out  N_CH*(DATA_W-4)  captured exit codes; channel c at [c*(DATA_W-4) +: DATA_W-4]
cycle_count_out  out  CNT_W  cycles since reset, frozen once all channels terminate

Behaviour:
- Reset: all outputs, state, counter, exit codes and sync flops go to 0. Every channel enters RUN.
- Write hit on channel c: ce & we & (addr[29:0] == BASE_ADDR[29:0] + c).
- Commands on a hit:
  - cmd 4'b0101 (PASS): RUN->PASS, exit_code[c] <= data[DATA_W-1:4].
  - cmd 4'b1100 (FAIL): RUN->FAIL, exit code captured the same way.
  - cmd 4'b1010: debug[c] toggles in any state.
  - Any other cmd: ignored.
- Channel state machine: RUN, PASS, FAIL, TOUT. All terminal states are sticky until reset. PASS/FAIL writes in a terminal state do not change the state or the exit code.
- Reads (ce & !we) and non-matching addresses: no effect.
- Cycle counter:
  - Increments each cycle while any channel is in RUN.
  - Saturates at all-ones; no wrap.
  - Stops on the edge where the last channel terminates.
- Watchdog: when TIMEOUT_CYCLES != 0 and the counter == TIMEOUT_CYCLES with some channel in RUN:
  - Every RUN channel moves to TOUT on the next edge.
  - The internal timeout flag sets; it is sticky.
- Simultaneous events: a PASS/FAIL write to channel c on the timeout cycle wins for c. Other RUN channels still go to TOUT.
- Undelayed status: term[c] = state != RUN; failbit[c] = state in {FAIL, TOUT}; all_done = &term.
- Delay: term, failbit, the timeout flag and all_done each pass through SYNC_STAGES flops.
- Latency with SYNC_STAGES=3: a PASS write sampled at edge k is visible in state at k. ready_out rises after edge k+3.
- exit_code_out and debug_out are not delayed, so the exit code is stable before ready_out rises.
- Reset mid-operation clears everything immediately, including the sync pipeline.

Decomposition:
- Package riscv_test_status_pkg holds:
  - command constants CMD_PASS=4'h5, CMD_FAIL=4'hC, CMD_DEBUG=4'hA;
  - the 2-bit channel state encoding RUN=0, PASS=1, FAIL=2, TOUT=3.
- Sub-module riscv_status_sync (width W, STAGES) implements the reset-clearable flop chain. It is instantiated once for the concatenated {all_done, timeout, fail, term} vector.

Test Plan:
- N_CH=2, TIMEOUT_CYCLES=0:
  - write addr 32'h1FF, data 8'h35 -> ready_out=2'b01 exactly 3 edges later, fail_out=0, exit_code_out[3:0]=4'h3.
- Write addr 32'h200, data 8'h7C -> ready_out[1]=1, fail_out[1]=1, exit code ch1=4'h7. all_done_out rises 3 edges after the later of the two writes, and cycle_count_out freezes.
- Three writes of data 8'h0A to 32'h1FF -> debug_out[0] sequence 1, 0, 1, with ready_out unchanged.
- TIMEOUT_CYCLES=20; PASS ch0 at cycle 5; no write to ch1:
  - ch1 -> TOUT; timeout_out=1, fail_out=2'b10, all_done_out=1;
  - cycle_count_out stays at 20.
- Boundary and error cases:
  - PASS ch1 on the exact timeout cycle -> ch1 PASS, not TOUT.
  - Write to addr 32'hC00001FF -> treated as a hit (top bits ignored).
  - Write to 32'h1FE -> ignored.
  - Second PASS with data 8'h95 after PASS -> exit code unchanged.
- Assert resetb low between the write and ready_out -> all outputs 0 at once, ready_out never pulses; after release the counter restarts from 0.
